board_engine: RTL and testbench

BOARD_ENGINE -- requirements
Module: board_engine

---
 rtl/board_engine_if.sv | 29 ++
 rtl/board_engine.sv | 211 +++++++++++++++++++++
 tb/tb_board_engine.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_engine_if.sv
// Move handshake, board preload and observable board state for board_engine.
// The master side drives moves and loads, and the slave side reports cells and status.
interface board_engine_if;
  logic        move_valid;
  logic [1:0]  move_dir;
  logic        move_ready;
  logic        load;
  logic [63:0] board_in;
  logic [3:0]  c1, c2, c3, c4, c5, c6, c7, c8;
  logic [3:0]  c9, c10, c11, c12, c13, c14, c15, c16;
  logic        done;
  logic        moved;
  logic        win;
  logic        full;

  modport master (
    output move_valid, move_dir, load, board_in,
    input  move_ready, done, moved, win, full,
    input  c1, c2, c3, c4, c5, c6, c7, c8,
    input  c9, c10, c11, c12, c13, c14, c15, c16
  );

  modport slave (
    input  move_valid, move_dir, load, board_in,
    output move_ready, done, moved, win, full,
    output c1, c2, c3, c4, c5, c6, c7, c8,
    output c9, c10, c11, c12, c13, c14, c15, c16
  );
endinterface

// File: rtl/board_engine.sv
// 4x4 sliding-tile game engine: slides and merges one line per cycle,
// then spawns a random tile using a 16-bit Fibonacci LFSR.
module board_engine #(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter logic [3:0]  WIN_EXP = 4'd11
) (
  input logic           clk,
  input logic           rst,
  board_engine_if.slave bus
);

  typedef enum logic [2:0] {INIT, IDLE, SLIDE, SPAWN, DONE} state_t;

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [3:0]  SEED_IDX = SEED_EFF[3:0];
  localparam logic [3:0]  SEED_VAL = (SEED_EFF[6:4] == 3'd0) ? 4'd2 : 4'd1;

  state_t           state_q, state_d;
  logic [15:0][3:0] cells_q, cells_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       line_q, line_d;
  logic             changed_q, changed_d;
  logic [3:0]       spawn_idx_q, spawn_idx_d;
  logic [3:0]       spawn_val_q, spawn_val_d;
  logic [3:0]       spawn_cnt_q, spawn_cnt_d;
  logic             init_cnt_q, init_cnt_d;
  logic             win_q, win_d;
  logic             full_q, full_d;

  logic [3:0][3:0]  cur_line;
  logic [3:0][3:0]  slid;
  logic [3:0]       spawn_pos;
  logic             spawn_hit;
  logic             spawn_end;
  logic [3:0]       next_val;

  // Position p of line j counts outward from the destination edge.
  function automatic logic [3:0] line_idx(input logic [1:0] dir,
                                          input logic [1:0] j,
                                          input logic [1:0] p);
    case (dir)
      2'd0:    line_idx = {p, j};
      2'd1:    line_idx = {~p, j};
      2'd2:    line_idx = {j, p};
      default: line_idx = {j, ~p};
    endcase
  endfunction

  function automatic logic [3:0][3:0] slide_line(input logic [3:0][3:0] line_in);
    logic [3:0]      t [5];
    logic [3:0][3:0] res;
    logic [1:0]      n;
    logic [1:0]      k;
    logic            skip;
    for (int i = 0; i < 5; i++) t[i] = 4'd0;
    res  = '0;
    n    = 2'd0;
    k    = 2'd0;
    skip = 1'b0;
    for (int p = 0; p < 4; p++) begin
      if (line_in[p] != 4'd0) begin
        t[n] = line_in[p];
        n    = n + 2'd1;
      end
    end
    // A merged cell is skipped as the left half of the next pair, so each cell merges once.
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (t[i] != 4'd0 && t[i] == t[i+1]) begin
        res[k] = (t[i] == 4'd15) ? 4'd15 : t[i] + 4'd1;
        k      = k + 2'd1;
        skip   = 1'b1;
      end else begin
        res[k] = t[i];
        k      = k + 2'd1;
      end
    end
    return res;
  endfunction

  always_comb begin
    state_d     = state_q;
    cells_d     = cells_q;
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    dir_d       = dir_q;
    line_d      = line_q;
    changed_d   = changed_q;
    spawn_idx_d = spawn_idx_q;
    spawn_val_d = spawn_val_q;
    spawn_cnt_d = spawn_cnt_q;
    init_cnt_d  = init_cnt_q;
    win_d       = 1'b0;
    full_d      = 1'b1;

    for (int k = 0; k < 16; k++) begin
      if (cells_q[k] >= WIN_EXP) win_d  = 1'b1;
      if (cells_q[k] == 4'd0)    full_d = 1'b0;
    end

    for (int p = 0; p < 4; p++) cur_line[p] = cells_q[line_idx(dir_q, line_q, 2'(p))];
    slid = slide_line(cur_line);

    spawn_pos = spawn_idx_q + spawn_cnt_q;
    spawn_hit = (cells_q[spawn_pos] == 4'd0);
    spawn_end = spawn_hit || (spawn_cnt_q == 4'd15);
    next_val  = (lfsr_q[6:4] == 3'd0) ? 4'd2 : 4'd1;

    case (state_q)
      INIT, SPAWN: begin
        if (spawn_hit) cells_d[spawn_pos] = spawn_val_q;
        if (spawn_end) begin
          spawn_cnt_d = 4'd0;
          if (state_q == SPAWN) begin
            state_d = DONE;
          end else if (init_cnt_q) begin
            state_d = IDLE;
          end else begin
            init_cnt_d  = 1'b1;
            spawn_idx_d = lfsr_q[3:0];
            spawn_val_d = next_val;
          end
        end else begin
          spawn_cnt_d = spawn_cnt_q + 4'd1;
        end
      end
      IDLE: begin
        if (bus.load) begin
          cells_d = bus.board_in;
        end else if (bus.move_valid) begin
          dir_d     = bus.move_dir;
          line_d    = 2'd0;
          changed_d = 1'b0;
          state_d   = SLIDE;
        end
      end
      SLIDE: begin
        for (int p = 0; p < 4; p++) cells_d[line_idx(dir_q, line_q, 2'(p))] = slid[p];
        changed_d = changed_q || (slid != cur_line);
        line_d    = line_q + 2'd1;
        if (line_q == 2'd3) begin
          if (changed_d) begin
            state_d     = SPAWN;
            spawn_idx_d = lfsr_q[3:0];
            spawn_val_d = next_val;
            spawn_cnt_d = 4'd0;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= INIT;
      cells_q     <= '0;
      lfsr_q      <= SEED_EFF;
      dir_q       <= 2'd0;
      line_q      <= 2'd0;
      changed_q   <= 1'b0;
      spawn_idx_q <= SEED_IDX;
      spawn_val_q <= SEED_VAL;
      spawn_cnt_q <= 4'd0;
      init_cnt_q  <= 1'b0;
      win_q       <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cells_q     <= cells_d;
      lfsr_q      <= lfsr_d;
      dir_q       <= dir_d;
      line_q      <= line_d;
      changed_q   <= changed_d;
      spawn_idx_q <= spawn_idx_d;
      spawn_val_q <= spawn_val_d;
      spawn_cnt_q <= spawn_cnt_d;
      init_cnt_q  <= init_cnt_d;
      win_q       <= win_d;
      full_q      <= full_d;
    end
  end

  assign bus.move_ready = (state_q == IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.moved      = (state_q == DONE) && changed_q;
  assign bus.win        = win_q;
  assign bus.full       = full_q;

  assign bus.c1  = cells_q[0];
  assign bus.c2  = cells_q[1];
  assign bus.c3  = cells_q[2];
  assign bus.c4  = cells_q[3];
  assign bus.c5  = cells_q[4];
  assign bus.c6  = cells_q[5];
  assign bus.c7  = cells_q[6];
  assign bus.c8  = cells_q[7];
  assign bus.c9  = cells_q[8];
  assign bus.c10 = cells_q[9];
  assign bus.c11 = cells_q[10];
  assign bus.c12 = cells_q[11];
  assign bus.c13 = cells_q[12];
  assign bus.c14 = cells_q[13];
  assign bus.c15 = cells_q[14];
  assign bus.c16 = cells_q[15];

endmodule

// File: tb/tb_board_engine.sv
// Directed bench for board_engine: boards are written as 64-bit hex with c1
// in the lowest nibble, and expected boards are worked out by hand.
module tb_board_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  board_engine_if bus();

  board_engine #(.SEED(16'hACE1), .WIN_EXP(4'd11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [63:0] get_board();
    return {bus.c16, bus.c15, bus.c14, bus.c13, bus.c12, bus.c11, bus.c10, bus.c9,
            bus.c8,  bus.c7,  bus.c6,  bus.c5,  bus.c4,  bus.c3,  bus.c2,  bus.c1};
  endfunction

  function automatic void count_tiles(input logic [63:0] b, output int nz, output int odd);
    logic [3:0] v;
    nz  = 0;
    odd = 0;
    for (int k = 0; k < 16; k++) begin
      v = b[4*k +: 4];
      if (v != 4'd0) nz++;
      if (v != 4'd0 && v != 4'd1 && v != 4'd2) odd++;
    end
  endfunction

  // Cells that differ from the hand-computed board: a new 1/2 in an expected-empty cell is a spawn.
  function automatic void diff_boards(input logic [63:0] act, input logic [63:0] exp,
                                      output int spawned, output int wrong);
    logic [3:0] a;
    logic [3:0] e;
    spawned = 0;
    wrong   = 0;
    for (int k = 0; k < 16; k++) begin
      a = act[4*k +: 4];
      e = exp[4*k +: 4];
      if (a !== e) begin
        if (e == 4'd0 && (a == 4'd1 || a == 4'd2)) spawned++;
        else wrong++;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.move_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic do_load(input logic [63:0] b, output bit ok);
    wait_ready(ok);
    bus.board_in = b;
    bus.load     = 1'b1;
    step();
    bus.load     = 1'b0;
  endtask

  // lat=1 is the cycle right after the accepting edge; lat counts up to the done cycle.
  task automatic do_move(input logic [1:0] dir, output int lat, output bit ok, output logic mv);
    lat = 0;
    mv  = 1'b0;
    wait_ready(ok);
    if (!ok) return;
    bus.move_dir   = dir;
    bus.move_valid = 1'b1;
    step();
    bus.move_valid = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    if (bus.done !== 1'b1) ok = 1'b0;
    mv = bus.moved;
  endtask

  task automatic test_reset();
    int nz, odd, cyc;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (get_board() !== 64'd0 || bus.move_ready !== 1'b0 || bus.done !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_hold: board=%h ready=%b done=%b want board=0 ready=0 done=0",
                 get_board(), bus.move_ready, bus.done);
      end
    end
    total++;
    if (bus.win !== 1'b0 || bus.full !== 1'b0 || bus.moved !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags: win=%b full=%b moved=%b want 0 0 0", bus.win, bus.full, bus.moved);
    end
    rst = 1'b1;
    cyc = 0;
    while (bus.move_ready !== 1'b1 && cyc < 34) begin
      step();
      cyc++;
    end
    total++;
    if (bus.move_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_ready: ready=%b after %0d cycles want 1 within 34", bus.move_ready, cyc);
    end
    count_tiles(get_board(), nz, odd);
    total++;
    if (nz !== 2 || odd !== 0) begin
      bad++;
      $display("[TB] FAIL reset_tiles: tiles=%0d badvals=%0d want tiles=2 badvals=0", nz, odd);
    end
  endtask

  task automatic test_merge_left();
    int lat, sp, wr;
    bit ok;
    logic mv;
    do_load(64'h0000_0000_0000_1111, ok);
    do_move(2'd2, lat, ok, mv);
    total++;
    if (!ok || mv !== 1'b1 || lat < 6 || lat > 21) begin
      bad++;
      $display("[TB] FAIL merge_left_flags: ok=%b moved=%b lat=%0d want ok=1 moved=1 lat 6..21", ok, mv, lat);
    end
    diff_boards(get_board(), 64'h0000_0000_0000_0022, sp, wr);
    total++;
    if (wr !== 0 || sp !== 1) begin
      bad++;
      $display("[TB] FAIL merge_left_board: board=%h wrong=%0d spawned=%0d want 0022 wrong=0 spawned=1",
               get_board(), wr, sp);
    end
  endtask

  task automatic test_merge_priority();
    int lat, sp, wr;
    bit ok;
    logic mv;
    do_load(64'h0000_0000_0000_0222, ok);
    do_move(2'd3, lat, ok, mv);
    diff_boards(get_board(), 64'h0000_0000_0000_3200, sp, wr);
    total++;
    if (!ok || mv !== 1'b1 || wr !== 0 || sp !== 1) begin
      bad++;
      $display("[TB] FAIL merge_priority: ok=%b moved=%b board=%h wrong=%0d spawned=%0d want 3200 moved=1",
               ok, mv, get_board(), wr, sp);
    end
  endtask

  task automatic test_vertical();
    int lat, sp, wr;
    bit ok;
    logic mv;
    do_load(64'h0002_0002_0001_0001, ok);
    do_move(2'd1, lat, ok, mv);
    diff_boards(get_board(), 64'h0003_0002_0000_0000, sp, wr);
    total++;
    if (!ok || mv !== 1'b1 || wr !== 0 || sp !== 1) begin
      bad++;
      $display("[TB] FAIL move_down: board=%h wrong=%0d spawned=%0d moved=%b want 0003000200000000",
               get_board(), wr, sp, mv);
    end
    do_load(64'h0030_0030_0000_0030, ok);
    do_move(2'd0, lat, ok, mv);
    diff_boards(get_board(), 64'h0000_0000_0030_0040, sp, wr);
    total++;
    if (!ok || mv !== 1'b1 || wr !== 0 || sp !== 1) begin
      bad++;
      $display("[TB] FAIL move_up: board=%h wrong=%0d spawned=%0d moved=%b want 0000000000300040",
               get_board(), wr, sp, mv);
    end
  endtask

  task automatic test_noop();
    int lat;
    bit ok;
    logic mv;
    do_load(64'h1212_2121_1212_2121, ok);
    do_move(2'd2, lat, ok, mv);
    total++;
    if (!ok || lat !== 5 || mv !== 1'b0) begin
      bad++;
      $display("[TB] FAIL noop_timing: ok=%b lat=%0d moved=%b want lat=5 moved=0", ok, lat, mv);
    end
    total++;
    if (get_board() !== 64'h1212_2121_1212_2121 || bus.full !== 1'b1) begin
      bad++;
      $display("[TB] FAIL noop_board: board=%h full=%b want 1212212112122121 full=1", get_board(), bus.full);
    end
  endtask

  task automatic test_win();
    int lat, sp, wr;
    bit ok;
    logic mv;
    do_load(64'h0000_0000_0000_00AA, ok);
    step();
    total++;
    if (bus.win !== 1'b0) begin
      bad++;
      $display("[TB] FAIL win_before: win=%b want 0", bus.win);
    end
    do_move(2'd2, lat, ok, mv);
    diff_boards(get_board(), 64'h0000_0000_0000_000B, sp, wr);
    total++;
    if (!ok || wr !== 0 || sp !== 1 || bus.win !== 1'b1) begin
      bad++;
      $display("[TB] FAIL win_after: board=%h wrong=%0d spawned=%0d win=%b want 000B win=1",
               get_board(), wr, sp, bus.win);
    end
  endtask

  task automatic test_saturate();
    int lat, sp, wr;
    bit ok;
    logic mv;
    do_load(64'h0000_0000_0000_00FF, ok);
    do_move(2'd2, lat, ok, mv);
    diff_boards(get_board(), 64'h0000_0000_0000_000F, sp, wr);
    total++;
    if (!ok || mv !== 1'b1 || wr !== 0 || sp !== 1) begin
      bad++;
      $display("[TB] FAIL saturate: board=%h wrong=%0d spawned=%0d moved=%b want 000F moved=1",
               get_board(), wr, sp, mv);
    end
  endtask

  task automatic test_load_priority();
    bit ok;
    int seen;
    wait_ready(ok);
    bus.board_in   = 64'h0000_0000_0000_0111;
    bus.load       = 1'b1;
    bus.move_valid = 1'b1;
    bus.move_dir   = 2'd2;
    step();
    bus.load       = 1'b0;
    bus.move_valid = 1'b0;
    total++;
    if (!ok || get_board() !== 64'h0000_0000_0000_0111) begin
      bad++;
      $display("[TB] FAIL load_priority_board: board=%h want 0000000000000111", get_board());
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done === 1'b1) seen++;
      step();
    end
    total++;
    if (seen !== 0 || bus.move_ready !== 1'b1 || get_board() !== 64'h0000_0000_0000_0111) begin
      bad++;
      $display("[TB] FAIL load_priority_idle: done_seen=%0d ready=%b board=%h want 0 1 0111",
               seen, bus.move_ready, get_board());
    end
  endtask

  task automatic test_back_to_back();
    int lat, sp, wr;
    bit ok;
    do_load(64'h0000_0000_0000_0011, ok);
    wait_ready(ok);
    bus.move_dir   = 2'd2;
    bus.move_valid = 1'b1;
    step();
    // Keep hammering load and move while busy; the engine must ignore both.
    bus.board_in = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.load     = 1'b1;
    bus.move_dir = 2'd3;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    bus.load       = 1'b0;
    bus.move_valid = 1'b0;
    diff_boards(get_board(), 64'h0000_0000_0000_0002, sp, wr);
    total++;
    if (bus.done !== 1'b1 || wr !== 0 || sp !== 1) begin
      bad++;
      $display("[TB] FAIL busy_ignore: done=%b board=%h wrong=%0d spawned=%0d want 0002",
               bus.done, get_board(), wr, sp);
    end
  endtask

  task automatic test_reset_abort();
    int nz, odd, cyc;
    bit ok;
    do_load(64'h0000_0000_0000_0011, ok);
    wait_ready(ok);
    bus.move_dir   = 2'd2;
    bus.move_valid = 1'b1;
    step();
    bus.move_valid = 1'b0;
    repeat (4) step();
    rst = 1'b0;
    step();
    total++;
    if (get_board() !== 64'd0 || bus.done !== 1'b0 || bus.move_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_reset: board=%h done=%b ready=%b want 0 0 0",
               get_board(), bus.done, bus.move_ready);
    end
    rst = 1'b1;
    cyc = 0;
    while (bus.move_ready !== 1'b1 && cyc < 34) begin
      step();
      cyc++;
    end
    count_tiles(get_board(), nz, odd);
    total++;
    if (bus.move_ready !== 1'b1 || nz !== 2 || odd !== 0) begin
      bad++;
      $display("[TB] FAIL abort_init: ready=%b tiles=%0d badvals=%0d want ready=1 tiles=2 badvals=0",
               bus.move_ready, nz, odd);
    end
  endtask

  initial begin
    bus.move_valid = 1'b0;
    bus.move_dir   = 2'd0;
    bus.load       = 1'b0;
    bus.board_in   = 64'd0;
    test_reset();
    test_merge_left();
    test_merge_priority();
    test_vertical();
    test_noop();
    test_win();
    test_saturate();
    test_load_priority();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
